// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: wb_sel sources, load funct3 codes, FSM states.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // True when the access cannot be served from a single naturally aligned lane.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] adr);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_LH || funct3 == F3_LHU) && adr[0]) mis = 1'b1;
    if (funct3 == F3_LW && adr != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load lane extraction and sign/zero extension.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      adr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[8*adr +: 8];
    half_lane = rdata[16*adr[1] +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: waits on data-memory responses, selects the source and drives the RF port.
// Optional WB_MISALIGN_CHECK_EN adds misalign_err and suppresses misaligned load writes.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3W,
  input  logic [XLEN-1:0] mem_adrW,
  input  logic [XLEN-1:0] pc_plus4W,
  input  logic [XLEN-1:0] alu_outW,
  input  logic [1:0]      wb_selW,
  input  logic            reg_writeW,
  input  logic [4:0]      rdW,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            load_timeout
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_load;
  logic            retire;
  logic            timeout;
  logic            misalign;
  logic            we;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            unused_adr;

  assign unused_adr = ^mem_adrW[XLEN-1:2];
  assign is_load    = reg_writeW && (wb_selW == WB_MEM);

  wb_stage_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3(funct3W),
    .adr   (mem_adrW[1:0]),
    .rdata (dmem_rdata),
    .data  (load_data)
  );

  always_comb begin
    case (wb_selW)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4W;
      default: wb_data = alu_outW;
    endcase
  end

`ifdef WB_MISALIGN_CHECK_EN
  assign misalign = is_load && is_misaligned(funct3W, mem_adrW[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_out = 1'b0;
    retire    = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_load && !dmem_rvalid) begin
          stall_out = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = CntW'(1);
        end else begin
          retire = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          retire  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CntW'(MAX_WAIT)) begin
          // Stall is held through the final wait cycle; released once back in IDLE.
          stall_out = 1'b1;
          timeout   = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign we = retire && reg_writeW && (rdW != 5'd0) && !misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rf_we        <= 1'b0;
      rf_wa        <= 5'd0;
      rf_wd        <= '0;
      load_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rf_we        <= we;
      load_timeout <= timeout;
      if (we) begin
        rf_wa <= rdW;
        rf_wd <= wb_data;
      end
    end
  end

`ifdef WB_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= retire && misalign;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes/timeouts queued, negedge monitor pops.
module tb_wb_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      funct3W;
  logic [XLEN-1:0] mem_adrW;
  logic [XLEN-1:0] pc_plus4W;
  logic [XLEN-1:0] alu_outW;
  logic [1:0]      wb_selW;
  logic            reg_writeW;
  logic [4:0]      rdW;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            stall_out;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            load_timeout;
`ifdef WB_MISALIGN_CHECK_EN
  logic            misalign_err;
`endif

  wb_stage #(
    .XLEN    (XLEN),
    .MAX_WAIT(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .funct3W     (funct3W),
    .mem_adrW    (mem_adrW),
    .pc_plus4W   (pc_plus4W),
    .alu_outW    (alu_outW),
    .wb_selW     (wb_selW),
    .reg_writeW  (reg_writeW),
    .rdW         (rdW),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall_out   (stall_out),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .load_timeout(load_timeout)
`ifdef WB_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_to;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic push_wr(input logic [4:0] wa, input logic [31:0] wd);
    ev_t e;
    e.is_to = 1'b0;
    e.wa    = wa;
    e.wd    = wd;
    exp_q.push_back(e);
  endtask

  task automatic push_to();
    ev_t e;
    e.is_to = 1'b1;
    e.wa    = 5'd0;
    e.wd    = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] alu,
                       input logic [31:0] pc, input logic rv, input logic [31:0] rdata);
    reg_writeW  = rw;
    wb_selW     = sel;
    rdW         = rd;
    funct3W     = f3;
    mem_adrW    = adr;
    alu_outW    = alu;
    pc_plus4W   = pc;
    dmem_rvalid = rv;
    dmem_rdata  = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 2'b01, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every write or timeout pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, rf_wa}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_kind", {31'd0, e.is_to}, 32'd0);
          check("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
          check("rf_wd", rf_wd, e.wd);
        end
      end
      if (load_timeout) begin
        if (exp_q.size() == 0) begin
          check("unexpected_timeout", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("timeout_kind", 32'd1, {31'd0, e.is_to});
        end
      end
    end
  end

  logic [2:0]  t_f3[8];
  logic [31:0] t_adr[8];
  logic [31:0] t_rdata[8];
  logic [31:0] t_exp[8];

  initial begin
    t_f3[0] = 3'b000; t_adr[0] = 32'h1003; t_rdata[0] = 32'h80FF_FF00; t_exp[0] = 32'hFFFF_FF80;
    t_f3[1] = 3'b100; t_adr[1] = 32'h1001; t_rdata[1] = 32'h80FF_FF00; t_exp[1] = 32'h0000_00FF;
    t_f3[2] = 3'b000; t_adr[2] = 32'h1000; t_rdata[2] = 32'h1234_567F; t_exp[2] = 32'h0000_007F;
    t_f3[3] = 3'b001; t_adr[3] = 32'h1002; t_rdata[3] = 32'h8001_0000; t_exp[3] = 32'hFFFF_8001;
    t_f3[4] = 3'b101; t_adr[4] = 32'h1000; t_rdata[4] = 32'h1234_F00D; t_exp[4] = 32'h0000_F00D;
    t_f3[5] = 3'b010; t_adr[5] = 32'h1000; t_rdata[5] = 32'hDEAD_BEEF; t_exp[5] = 32'hDEAD_BEEF;
    t_f3[6] = 3'b011; t_adr[6] = 32'h1000; t_rdata[6] = 32'hCAFE_BABE; t_exp[6] = 32'hCAFE_BABE;
    t_f3[7] = 3'b000; t_adr[7] = 32'h1002; t_rdata[7] = 32'h0085_0000; t_exp[7] = 32'hFFFF_FF85;

    rst = 1'b1;
    idle();
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_rf_wa", {27'd0, rf_wa}, 32'd0);
    check("reset_rf_wd", rf_wd, 32'd0);
    check("reset_timeout", {31'd0, load_timeout}, 32'd0);
    check("reset_stall", {31'd0, stall_out}, 32'd0);
    step();

    // ALU writeback, then rf_we must drop.
    drive(1'b1, 2'b01, 5'd5, 3'b000, 32'h0, 32'h1234, 32'h0, 1'b0, 32'h0);
    push_wr(5'd5, 32'h1234);
    #1 check("alu_stall", {31'd0, stall_out}, 32'd0);
    step();
    idle();
    step();
    check("alu_we_drop", {31'd0, rf_we}, 32'd0);

    // PC+4 and reserved select.
    drive(1'b1, 2'b10, 5'd1, 3'b000, 32'h0, 32'h5555, 32'h104, 1'b0, 32'h0);
    push_wr(5'd1, 32'h104);
    step();
    drive(1'b1, 2'b11, 5'd2, 3'b000, 32'h0, 32'hA5A5_0001, 32'h200, 1'b0, 32'h0);
    push_wr(5'd2, 32'hA5A5_0001);
    step();

    // x0 is never written; rvalid in IDLE without a load is ignored.
    drive(1'b1, 2'b01, 5'd0, 3'b000, 32'h0, 32'h7777, 32'h0, 1'b1, 32'h0);
    step();
    idle();
    step();
    check("x0_no_write", {31'd0, rf_we}, 32'd0);

    // Zero-wait loads, back to back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b00, 5'(7 + i), t_f3[i], t_adr[i], 32'h0, 32'h0, 1'b1, t_rdata[i]);
      push_wr(5'(7 + i), t_exp[i]);
      #1 check("zero_wait_stall", {31'd0, stall_out}, 32'd0);
      step();
    end
    idle();
    step();

    // Delayed LHU: response three cycles after issue.
    drive(1'b1, 2'b00, 5'd9, 3'b101, 32'h2002, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1 check("lhu_stall_hi", {31'd0, stall_out}, 32'd1);
      step();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0000;
    push_wr(5'd9, 32'h0000_BEEF);
    #1 check("lhu_stall_lo", {31'd0, stall_out}, 32'd0);
    step();
    idle();
    step();

    // Timeout: no response for 15 wait cycles.
    drive(1'b1, 2'b00, 5'd10, 3'b010, 32'h3000, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 check("to_stall_issue", {31'd0, stall_out}, 32'd1);
    step();
    for (int w = 1; w <= 15; w++) begin
      check("to_stall_wait", {31'd0, stall_out}, 32'd1);
      if (w == 15) push_to();
      step();
    end
    idle();
    #1 check("to_stall_release", {31'd0, stall_out}, 32'd0);
    check("to_pulse_hi", {31'd0, load_timeout}, 32'd1);
    step();
    check("to_pulse_lo", {31'd0, load_timeout}, 32'd0);

    // Reset in WAIT cycle 2; a late response is ignored.
    drive(1'b1, 2'b00, 5'd11, 3'b010, 32'h3000, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    check("rstw_stall_wait", {31'd0, stall_out}, 32'd1);
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    #1 check("rstw_stall", {31'd0, stall_out}, 32'd0);
    check("rstw_we", {31'd0, rf_we}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    step();
    idle();
    step();
    check("rstw_late_we", {31'd0, rf_we}, 32'd0);

`ifdef WB_MISALIGN_CHECK_EN
    drive(1'b1, 2'b00, 5'd12, 3'b010, 32'h4002, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
    step();
    idle();
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_no_write", {31'd0, rf_we}, 32'd0);
    step();
    check("mis_err_drop", {31'd0, misalign_err}, 32'd0);
`else
    // Misaligned half uses adr[1] only.
    drive(1'b1, 2'b00, 5'd12, 3'b001, 32'h4001, 32'h0, 32'h0, 1'b1, 32'h1234_9ABC);
    push_wr(5'd12, 32'hFFFF_9ABC);
    step();
    idle();
    step();
`endif

    repeat (2) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
